// File: rtl/knight_fade_if.sv
// knight_fade_if: link between the knight flasher and its fade/PWM output stage.
//   step  : one-cycle pulse, the flasher pattern advanced this cycle
//   pat   : WIDTH-bit head pattern, meaningful only while step=1
//   led   : WIDTH-bit PWM drive back from the fade stage, active-high
//   frame : one-cycle pulse at the start of each PWM period, aligned with led
// Modports: master = flasher side (drives step/pat), slave = fade stage.
interface knight_fade_if #(
  parameter int unsigned WIDTH = 8
);
  logic             step;
  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] led;
  logic             frame;

  modport master (
    output step,
    output pat,
    input  led,
    input  frame
  );

  modport slave (
    input  step,
    input  pat,
    output led,
    output frame
  );
endinterface

// File: rtl/knight_fade.sv
// knight_fade: per-LED brightness/PWM stage downstream of the knight flasher.
//
// Lit pattern bits jump their LED to full brightness; unlit LEDs decay by a right shift
// per applied step, which leaves a fading trail behind the scanner head. Level changes
// are only committed on the last cycle of a PWM period so a period never glitches.
//
// Ports:
//   ck     : clock
//   res_n  : asynchronous active-low reset
//   bus    : knight_fade_if.slave (step/pat in, led/frame out)
//
// Parameters:
//   WIDTH       : number of LEDs
//   BW          : brightness/PWM resolution in bits, MAX = 2^BW-1, period = MAX cycles
//   DECAY_SHIFT : right shift applied to an unlit LED per applied step (1..BW)
//
// Build option:
//   KNIGHT_FADE_GAMMA_EN : when defined, duty = (level*(level+1)) >> BW instead of
//                          duty = level; timing is identical in both builds.
module knight_fade #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned BW          = 4,
  parameter int unsigned DECAY_SHIFT = 1
) (
  input logic          ck,
  input logic          res_n,
  knight_fade_if.slave bus
);

  localparam logic [BW-1:0] MAX      = {BW{1'b1}};
  localparam logic [BW-1:0] CNT_LAST = {{(BW-1){1'b1}}, 1'b0};
  localparam logic [BW-1:0] CNT_ONE  = {{(BW-1){1'b0}}, 1'b1};

  if ((DECAY_SHIFT < 1) || (DECAY_SHIFT > BW)) begin : g_bad_shift
    $error("knight_fade: DECAY_SHIFT must lie in 1..BW");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [BW-1:0]             r_pwm_cnt;
  logic                      r_pending;
  logic [WIDTH-1:0]          r_pend_pat;
  logic [WIDTH-1:0][BW-1:0]  r_level;
  logic [WIDTH-1:0]          r_led;
  logic                      r_frame;

  // ---------------------------------------------------------------------------
  // Next-state / combinational signals
  // ---------------------------------------------------------------------------
  logic                      w_wrap;
  logic                      w_apply;
  logic [WIDTH-1:0]          w_eff_pat;
  logic [BW-1:0]             w_pwm_cnt_d;
  logic                      w_pending_d;
  logic [WIDTH-1:0]          w_pend_pat_d;
  logic [WIDTH-1:0][BW-1:0]  w_level_d;
  logic [WIDTH-1:0][BW-1:0]  w_duty;
  logic [WIDTH-1:0]          w_led_d;
  logic                      w_frame_d;

  // Last cycle of the PWM period; the only cycle on which levels may change.
  assign w_wrap = (r_pwm_cnt == CNT_LAST);

  // A step arriving on the wrap cycle itself is applied immediately rather than parked.
  assign w_eff_pat = bus.step ? bus.pat : r_pend_pat;
  assign w_apply   = w_wrap && (bus.step || r_pending);

  // PWM counter: 0..MAX-1 then back to 0.
  always_comb begin
    w_pwm_cnt_d = r_pwm_cnt + CNT_ONE;
    if (w_wrap) begin
      w_pwm_cnt_d = '0;
    end
  end

  // Step capture: the last step seen in a period is the one that gets applied.
  always_comb begin
    w_pending_d  = r_pending;
    w_pend_pat_d = r_pend_pat;
    if (w_wrap) begin
      w_pending_d = 1'b0;
    end else if (bus.step) begin
      w_pending_d  = 1'b1;
      w_pend_pat_d = bus.pat;
    end
  end

  // Level update: lit bits go to MAX, unlit bits decay; the shift floors at zero.
  always_comb begin
    w_level_d = r_level;
    if (w_apply) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        w_level_d[i] = w_eff_pat[i] ? MAX : (r_level[i] >> DECAY_SHIFT);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Duty mapping
  // ---------------------------------------------------------------------------
`ifdef KNIGHT_FADE_GAMMA_EN
  // Approximate square law; the product fits in 2*BW+1 bits before truncation.
  logic [WIDTH-1:0][2*BW:0] w_prod;

  always_comb begin
    w_prod = '0;
    w_duty = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_prod[i] = {{(BW+1){1'b0}}, r_level[i]} *
                  ({{(BW+1){1'b0}}, r_level[i]} + {{(2*BW){1'b0}}, 1'b1});
      w_duty[i] = BW'(w_prod[i] >> BW);
    end
  end
`else
  always_comb begin
    w_duty = r_level;
  end
`endif

  // ---------------------------------------------------------------------------
  // Output decode: registered, one cycle behind pwm_cnt
  // ---------------------------------------------------------------------------
  always_comb begin
    w_led_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_led_d[i] = (r_pwm_cnt < w_duty[i]);
    end
    w_frame_d = (r_pwm_cnt == '0);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ck or negedge res_n) begin
    if (!res_n) begin
      r_pwm_cnt  <= '0;
      r_pending  <= 1'b0;
      r_pend_pat <= '0;
      r_level    <= '0;
    end else begin
      r_pwm_cnt  <= w_pwm_cnt_d;
      r_pending  <= w_pending_d;
      r_pend_pat <= w_pend_pat_d;
      r_level    <= w_level_d;
    end
  end

  always_ff @(posedge ck or negedge res_n) begin
    if (!res_n) begin
      r_led   <= '0;
      r_frame <= 1'b0;
    end else begin
      r_led   <= w_led_d;
      r_frame <= w_frame_d;
    end
  end

  assign bus.led   = r_led;
  assign bus.frame = r_frame;

endmodule

// File: tb/tb_knight_fade.sv
// tb_knight_fade: bench for knight_fade (WIDTH=8, BW=4, DECAY_SHIFT=1).
// Every cycle the outputs are compared with a behavioural model; a table of per-period
// step scenarios additionally checks the high count of each LED over a whole period.
module tb_knight_fade;

  localparam int W    = 8;
  localparam int MAXV = 15;

  logic ck    = 1'b0;
  logic res_n = 1'b0;

  knight_fade_if #(.WIDTH(W)) bus ();

  knight_fade #(
    .WIDTH      (W),
    .BW         (4),
    .DECAY_SHIFT(1)
  ) dut (
    .ck   (ck),
    .res_n(res_n),
    .bus  (bus)
  );

  always #5 ck = ~ck;

  int checks = 0;
  int errors = 0;

  // Model state: position in the period, brightness per LED, last step pattern seen
  // this period (-1 when none).
  int m_phase;
  int m_lvl[W];
  int m_pend;

  function automatic int duty(input int l);
`ifdef KNIGHT_FADE_GAMMA_EN
    return (l * (l + 1)) / 16;
`else
    return l;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pend  = -1;
    for (int i = 0; i < W; i++) m_lvl[i] = 0;
  endtask

  // One clock: drive inputs, let the edge happen, compare outputs, advance the model.
  task automatic cycle(input bit st, input logic [7:0] pt);
    int exp_led;
    int p;
    bus.step = st;
    bus.pat  = pt;
    @(posedge ck);
    #1;
    exp_led = 0;
    for (int i = 0; i < W; i++) begin
      if (m_phase < duty(m_lvl[i])) exp_led = exp_led | (1 << i);
    end
    check("led", int'(bus.led), exp_led);
    check("frame", int'(bus.frame), int'(m_phase == 0));
    if (m_phase == MAXV - 1) begin
      p = st ? int'(pt) : m_pend;
      if (p >= 0) begin
        for (int i = 0; i < W; i++) m_lvl[i] = p[i] ? MAXV : m_lvl[i] / 2;
      end
      m_pend = -1;
    end else if (st) begin
      m_pend = int'(pt);
    end
    m_phase = (m_phase + 1) % MAXV;
  endtask

  // Assert reset between clock edges and check outputs clear at once.
  task automatic async_reset();
    #2;
    res_n    = 1'b0;
    bus.step = 1'b0;
    #1;
    check("rst_led", int'(bus.led), 0);
    check("rst_frame", int'(bus.frame), 0);
    @(negedge ck);
    res_n = 1'b1;
    model_reset();
  endtask

  // One period of stimulus; off=15 means no step. lvl holds the expected level per LED
  // (nibble i = LED i) in force during this period.
  typedef struct {
    int         off1;
    logic [7:0] pat1;
    int         off2;
    logic [7:0] pat2;
    logic [31:0] lvl;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cnt[W];
    int frames;
    bit st;
    logic [7:0] pt;
    logic [31:0] lv;

    tbl[0]  = '{5,  8'h01, 15, 8'h00, 32'h0000_0000};
    tbl[1]  = '{15, 8'h00, 15, 8'h00, 32'h0000_000F};
    tbl[2]  = '{3,  8'h02, 15, 8'h00, 32'h0000_000F};
    tbl[3]  = '{7,  8'h04, 15, 8'h00, 32'h0000_00F7};
    tbl[4]  = '{15, 8'h00, 15, 8'h00, 32'h0000_0F73};
    tbl[5]  = '{15, 8'h00, 15, 8'h00, 32'h0000_0F73};
    tbl[6]  = '{2,  8'h01, 15, 8'h00, 32'h0000_0F73};
    tbl[7]  = '{2,  8'h01, 9,  8'h80, 32'h0000_073F};
    tbl[8]  = '{15, 8'h00, 15, 8'h00, 32'hF000_0317};
    tbl[9]  = '{14, 8'h10, 15, 8'h00, 32'hF000_0317};
    tbl[10] = '{15, 8'h00, 15, 8'h00, 32'h700F_0103};
    tbl[11] = '{4,  8'h01, 14, 8'h02, 32'h700F_0103};
    tbl[12] = '{15, 8'h00, 15, 8'h00, 32'h3007_00F1};

    bus.step = 1'b0;
    bus.pat  = '0;
    #1;
    check("por_led", int'(bus.led), 0);
    check("por_frame", int'(bus.frame), 0);
    @(negedge ck);
    res_n = 1'b1;
    model_reset();

    // Randomised traffic against the model.
    for (int n = 0; n < 300; n++) begin
      cycle(($urandom_range(0, 5) == 0), 8'($urandom));
    end

    // Leave a step pending, then reset mid-period: it must be discarded.
    cycle(1'b1, 8'hFF);
    async_reset();

    // Table-driven period scenarios, starting at the first period after reset.
    for (int k = 0; k < 13; k++) begin
      for (int i = 0; i < W; i++) cnt[i] = 0;
      frames = 0;
      for (int j = 0; j < MAXV; j++) begin
        st = (j == tbl[k].off1) || (j == tbl[k].off2);
        pt = (j == tbl[k].off2) ? tbl[k].pat2 : tbl[k].pat1;
        cycle(st, pt);
        for (int i = 0; i < W; i++) cnt[i] += int'(bus.led[i]);
        frames += int'(bus.frame);
      end
      lv = tbl[k].lvl;
      for (int i = 0; i < W; i++) begin
        check($sformatf("cnt_vec%0d_led%0d", k, i), cnt[i], duty(int'(lv[i*4 +: 4])));
      end
      check($sformatf("frames_vec%0d", k), frames, 1);
    end

    // More random traffic after the table, then a final reset check.
    for (int n = 0; n < 150; n++) begin
      cycle(($urandom_range(0, 3) == 0), 8'($urandom));
    end
    async_reset();
    for (int n = 0; n < 20; n++) cycle(1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
